// File: rtl/cvt_write_packer.sv
// Coalesces per-thread next-basic-block reports into 64-bit bitmap writes,
// keyed by (basic block, 64-thread chunk), for the CVT write port.
module cvt_write_packer #(
    parameter int THD_W   = 10,
    parameter int BB_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [THD_W-1:0] in_thd,
    input  logic [BB_W-1:0]  in_bb,
    input  logic             flush,
    output logic             W_req,
    output logic [BB_W-1:0]  WriteReg,
    output logic [THD_W-1:0] offset,
    output logic [63:0]      d_in,
    output logic             pending,
    output logic             dup_err
);
    localparam int CH_W  = THD_W - 6;
    localparam int AGE_W = $clog2(TIMEOUT);

    typedef enum logic {EMPTY, FILL} state_t;

    typedef struct packed {
        logic [BB_W-1:0] bb;
        logic [CH_W-1:0] chunk;
    } key_t;

    state_t             state, state_nxt;
    key_t               acc_key, in_key;
    logic [63:0]        acc_map, map_nxt, emit_word, onehot, merged;
    logic [AGE_W-1:0]   age, age_nxt;
    logic               load, emit, dup_hit, age_last, same_key;

    assign in_key   = '{bb: in_bb, chunk: in_thd[THD_W-1:6]};
    assign onehot   = 64'd1 << in_thd[5:0];
    assign merged   = acc_map | onehot;
    assign same_key = (in_key == acc_key);
    assign age_last = (age == AGE_W'(TIMEOUT - 1));
    assign pending  = (state == FILL);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        emit      = 1'b0;
        emit_word = acc_map;
        map_nxt   = acc_map;
        age_nxt   = age;
        dup_hit   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (in_valid && !same_key) begin
                    // Old word leaves on the same edge the new report is captured.
                    emit = 1'b1;
                    load = 1'b1;
                end else if (in_valid) begin
                    dup_hit = |(acc_map & onehot);
                    if (&merged || flush || age_last) begin
                        emit      = 1'b1;
                        emit_word = merged;
                        state_nxt = EMPTY;
                    end else begin
                        map_nxt = merged;
                        age_nxt = age + AGE_W'(1);
                    end
                end else if (flush || age_last) begin
                    emit      = 1'b1;
                    state_nxt = EMPTY;
                end else begin
                    age_nxt = age + AGE_W'(1);
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (load) begin
            map_nxt = onehot;
            age_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            acc_key <= '0;
            acc_map <= '0;
            age     <= '0;
        end else begin
            state   <= state_nxt;
            acc_map <= map_nxt;
            age     <= age_nxt;
            if (load) acc_key <= in_key;
        end
    end

    // Address/data hold their last write; only the strobe returns to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            W_req    <= 1'b0;
            WriteReg <= '0;
            offset   <= '0;
            d_in     <= '0;
            dup_err  <= 1'b0;
        end else begin
            W_req <= emit;
            if (emit) begin
                WriteReg <= acc_key.bb;
                offset   <= {acc_key.chunk, 6'b0};
                d_in     <= emit_word;
            end
            if (dup_hit) dup_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cvt_write_packer.sv
// Bench for cvt_write_packer: two instances (short and long timeout) driven in
// lockstep and compared every cycle against a deadline-based reference model.
module tb_cvt_write_packer;
    localparam int THD_W = 10;
    localparam int BB_W  = 5;
    localparam int TO0   = 16;
    localparam int TO1   = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             flush = 1'b0;
    logic [THD_W-1:0] in_thd = '0;
    logic [BB_W-1:0]  in_bb = '0;

    logic             w_req [2];
    logic [BB_W-1:0]  wreg  [2];
    logic [THD_W-1:0] offs  [2];
    logic [63:0]      dat   [2];
    logic             pend  [2];
    logic             dup   [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cvt_write_packer #(.THD_W(THD_W), .BB_W(BB_W), .TIMEOUT(TO0)) u_short (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_thd(in_thd), .in_bb(in_bb),
        .flush(flush), .W_req(w_req[0]), .WriteReg(wreg[0]), .offset(offs[0]),
        .d_in(dat[0]), .pending(pend[0]), .dup_err(dup[0]));

    cvt_write_packer #(.THD_W(THD_W), .BB_W(BB_W), .TIMEOUT(TO1)) u_long (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_thd(in_thd), .in_bb(in_bb),
        .flush(flush), .W_req(w_req[1]), .WriteReg(wreg[1]), .offset(offs[1]),
        .d_in(dat[1]), .pending(pend[1]), .dup_err(dup[1]));

    // Reference model: a held word has an absolute deadline edge instead of an age.
    bit               m_held [2];
    logic [BB_W-1:0]  m_bb   [2];
    logic [3:0]       m_ch   [2];
    logic [63:0]      m_map  [2];
    int               m_dl   [2];
    bit               e_w    [2];
    logic [BB_W-1:0]  e_reg  [2];
    logic [THD_W-1:0] e_off  [2];
    logic [63:0]      e_d    [2];
    bit               e_dup  [2];
    int               edge_n = 0;

    function automatic int to_of(int i);
        return (i == 0) ? TO0 : TO1;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_held[i] = 0; e_w[i] = 0; e_reg[i] = '0; e_off[i] = '0;
            e_d[i] = '0; e_dup[i] = 0; m_map[i] = '0;
        end
    endtask

    task automatic emit(int i, logic [63:0] w);
        e_w[i]   = 1;
        e_reg[i] = m_bb[i];
        e_off[i] = {m_ch[i], 6'b0};
        e_d[i]   = w;
        m_held[i] = 0;
    endtask

    task automatic model_edge();
        logic [63:0] oh;
        oh = 64'd1 << in_thd[5:0];
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            e_w[i] = 0;
            if (m_held[i] && in_valid && in_bb == m_bb[i] && in_thd[9:6] == m_ch[i]) begin
                if ((m_map[i] & oh) != 0) e_dup[i] = 1;
                m_map[i] = m_map[i] | oh;
                if (m_map[i] == '1 || flush || edge_n == m_dl[i]) emit(i, m_map[i]);
            end else if (in_valid) begin
                if (m_held[i]) emit(i, m_map[i]);
                m_held[i] = 1; m_bb[i] = in_bb; m_ch[i] = in_thd[9:6];
                m_map[i] = oh; m_dl[i] = edge_n + to_of(i);
            end else if (m_held[i] && (flush || edge_n == m_dl[i])) begin
                emit(i, m_map[i]);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("w_req%0d", i),   64'(w_req[i]), 64'(e_w[i]));
            chk($sformatf("wreg%0d", i),    64'(wreg[i]),  64'(e_reg[i]));
            chk($sformatf("offset%0d", i),  64'(offs[i]),  64'(e_off[i]));
            chk($sformatf("d_in%0d", i),    dat[i],        e_d[i]);
            chk($sformatf("pending%0d", i), 64'(pend[i]),  64'(m_held[i]));
            chk($sformatf("dup_err%0d", i), 64'(dup[i]),   64'(e_dup[i]));
        end
    endtask

    task automatic step(bit v, int thd, int bb, bit fl);
        in_valid = v;
        in_thd   = thd[THD_W-1:0];
        in_bb    = bb[BB_W-1:0];
        flush    = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        @(negedge clk) rst = 1'b1;

        // coalesce threads 0..7 into BB 3, then flush
        for (int t = 0; t < 8; t++) step(1, t, 3, 0);
        step(0, 0, 0, 1);
        chk("coal_wreq", 64'(w_req[0]), 64'd1);
        chk("coal_reg",  64'(wreg[0]),  64'd3);
        chk("coal_off",  64'(offs[0]),  64'd0);
        chk("coal_d",    dat[0],        64'hFF);
        step(0, 0, 0, 0);
        chk("coal_pend", 64'(pend[0]), 64'd0);
        chk("coal_once", 64'(w_req[0]), 64'd0);

        // key change: same BB, next chunk
        step(1, 5, 2, 0);
        step(1, 70, 2, 0);
        chk("key1_wreq", 64'(w_req[0]), 64'd1);
        chk("key1_off",  64'(offs[0]),  64'd0);
        chk("key1_d",    dat[0],        64'h20);
        step(0, 0, 0, 1);
        chk("key2_wreq", 64'(w_req[0]), 64'd1);
        chk("key2_off",  64'(offs[0]),  64'd64);
        chk("key2_d",    dat[0],        64'h40);

        // full word on the long-timeout instance
        for (int t = 0; t < 64; t++) step(1, 128 + t, 7, 0);
        chk("full_wreq", 64'(w_req[1]), 64'd1);
        chk("full_off",  64'(offs[1]),  64'd128);
        chk("full_reg",  64'(wreg[1]),  64'd7);
        chk("full_d",    dat[1],        64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 0, 0, 0);
        chk("full_pend", 64'(pend[1]), 64'd0);
        chk("full_once", 64'(w_req[1]), 64'd0);
        step(0, 0, 0, 1);

        // timeout on the 16-edge instance
        step(1, 1, 0, 0);
        for (int k = 1; k < TO0; k++) begin
            step(0, 0, 0, 0);
            chk("to_early", 64'(w_req[0]), 64'd0);
        end
        step(0, 0, 0, 0);
        chk("to_wreq", 64'(w_req[0]), 64'd1);
        chk("to_d",    dat[0],        64'h2);
        for (int k = 0; k < 50; k++) step(0, 0, 0, 0);

        // duplicate report
        step(1, 9, 1, 0);
        step(1, 9, 1, 0);
        step(0, 0, 0, 1);
        chk("dup_d",   dat[0],       64'h200);
        chk("dup_err", 64'(dup[0]),  64'd1);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
        chk("dup_hold", 64'(dup[0]), 64'd1);

        // randomized traffic with frequent key collisions
        for (int k = 0; k < 600; k++)
            step($urandom_range(3, 0) != 0, int'($urandom_range(191, 0)),
                 int'($urandom_range(2, 0)), $urandom_range(15, 0) == 0);

        // asynchronous reset while holding a word
        step(1, 300, 4, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 100; k++) step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cvt_write_packer.md
# cvt_write_packer

Producer side of the CVT write port. Collects per-thread "next basic block" reports from the execution lanes and coalesces them into 64-bit bitmap words keyed by (basic block, 64-thread chunk). It then drives the `W_req` / `WriteReg` / `offset` / `d_in` write interface consumed by the basic-block sequencer, CVT and termination counter. Each reported thread appears as exactly one set bit in exactly one write.

## Interface
Parameters:
- `THD_W`, 10: thread ID width (1024 threads).
- `BB_W`, 5: basic-block index width.
- `TIMEOUT`, 16: maximum edges a partially filled word is held. Legal range is 2..256.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: a thread report is present this cycle. Always accepted; there is no backpressure.
- `in_thd`, input, `THD_W`: reporting thread ID.
- `in_bb`, input, `BB_W`: basic block the thread runs next.
- `flush`, input, 1: level-sensitive. While high, any held word is emitted.
- `W_req`, output, 1: write strobe, high for one cycle per word.
- `WriteReg`, output, `BB_W`: target basic block.
- `offset`, output, `THD_W`: chunk base, equal to `{chunk, 6'b0}`.
- `d_in`, output, 64: thread bitmap. Bit i is thread `offset + i`.
- `pending`, output, 1: a word is currently held.
- `dup_err`, output, 1: sticky; the same thread was reported twice into one held word.

## Operation
- Key of a report is `{in_bb, in_thd[9:6]}`. Bit index is `in_thd[5:0]`.
- Internal state:
  - accumulator `acc_bb`, `acc_chunk`, `acc_map[63:0]`;
  - age counter of width clog2(`TIMEOUT`);
  - FSM with states EMPTY and FILL.
- EMPTY:
  - `in_valid` loads the key and a one-hot map, sets age=0, and moves to FILL.
  - `flush` has no effect in EMPTY.
- FILL: evaluated at each edge, first matching rule wins.
  1. `in_valid` with a different key: emit the held word unchanged. Load the new report with age=0 and stay in FILL.
  2. `in_valid` with the same key: merged = `acc_map | onehot`. If the bit was already set, set `dup_err` (the merge is still idempotent). If merged is all ones, or `flush` is high, or age==`TIMEOUT`-1, emit merged and go to EMPTY. Otherwise keep merged and increment age.
  3. No `in_valid`: if `flush` is high or age==`TIMEOUT`-1, emit and go to EMPTY. Otherwise increment age.
- Age is not reset by same-key merges, so latency from first report to write is bounded.
- "Emit" means that at the edge, the output registers load `W_req`=1, `WriteReg`=`acc_bb`, `offset`=`{acc_chunk, 6'b0}`, and `d_in`=the word.
- On edges with no emit, `W_req` goes to 0. `WriteReg`, `offset` and `d_in` hold their last values.
- `pending` is 1 exactly when the state is FILL.
- The downstream CVT write port merges the bits it receives. The termination counter receives popcount(`d_in`).

## Timing
- All outputs are registered. The reset value of every output is 0, and the FSM resets to EMPTY.
- Reset asserted mid-FILL discards the held word: no write occurs, and `pending` and `W_req` drop asynchronously.
- Flush or full-word emit: a report accepted at edge N with a same-key emit trigger gives `W_req`=1 in cycle N..N+1.
- A report loaded from EMPTY at edge N is emitted no later than edge N+`TIMEOUT`.
- If `flush` is high at the load edge N, the emit happens at edge N+1.
- Key change: the old word is written at the same edge the new report is loaded. Back-to-back writes on consecutive cycles are legal.
- `dup_err` sets at the offending edge and clears only on reset.

## Test plan
- **Reset:** drive `rst`=0 mid-run.
  - All outputs read 0 immediately.
  - After release, with no `in_valid`, `W_req` stays 0 for 100 cycles.
- **Coalesce and flush:** threads 0..7 to BB 3 on consecutive cycles, then `flush` for one cycle.
  - Exactly one `W_req`: `WriteReg`=3, `offset`=0, `d_in`=0xFF.
  - `pending`=0 afterwards.
- **Key change:** thread 5 to BB 2, next cycle thread 70 to BB 2, then `flush`.
  - First write: `WriteReg`=2, `offset`=0, `d_in`=0x20, at the edge accepting thread 70.
  - Second write: `offset`=64, `d_in`=0x40.
- **Full word:** threads 128..191 to BB 7 on 64 consecutive cycles.
  - One write at the 64th edge: `offset`=128, `d_in`=all ones.
  - `pending`=0 the next cycle, with no further write.
- **Timeout:** `TIMEOUT`=16, thread 1 to BB 0 at edge N, no other activity.
  - `W_req` at edge N+16 with `d_in`=0x2. Nothing before that edge.
- **Duplicate:** thread 9 to BB 1 twice, then `flush`.
  - `d_in`=0x200 and `dup_err`=1.
  - `dup_err` holds until reset.
